st4_mem: RTL and testbench
==========================

# st4_mem

Stage 4 of the 16-bit pipelined datapath. It holds the EX/MEM pipeline register and consumes the stage-3 ALU results, function code and exception flag. It runs byte and word loads and stores against an internal byte-wide data memory and presents registered writeback results to stage 5. Word accesses take two cycles on the byte-wide memory, so this stage stalls stage 3 for one cycle per word access.

## Interface
- DMEM_BYTES, 256, data memory size in bytes; power of two.
- ADDR_W, 8, memory address width; log2(DMEM_BYTES).

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  stage-3 result valid this cycle.
- ex_op  in  4  ALU function code carried from stage 3.
- ex_alu_out1  in  16  primary ALU result; the effective address for memory ops.
- ex_alu_out2  in  16  secondary result: mul high half, div remainder, swap second value.
- ex_store_data  in  16  store source register value.
- ex_dest  in  4  destination register number.
- ex_exception  in  1  stage-3 overflow exception.
- mem_stall  out  1  stage 3 must hold all ex_* inputs this cycle.
- wb_valid  out  1  writeback bundle valid.
- wb_dest  out  4  destination register.
- wb_data1  out  16  value for the destination register.
- wb_data2  out  16  value for R15.
- wb_wr1  out  1  write wb_data1 to wb_dest.
- wb_wr2  out  1  write wb_data2 to R15.
- exc_pulse  out  1  one-cycle pulse when an instruction is squashed by an exception.
- exc_sticky  out  1  set by any exception; cleared only by reset.

## Operation
- Accept condition: ex_valid=1 and mem_stall=0 at a rising edge.
- ALU-only ops (0000 add, 0001 sub, 0010 andi, 0111 move, 1001 ori):
  - wb_data1 = ex_alu_out1; wb_wr1=1; wb_wr2=0.
- Two-result ops (0100 mul, 0101 div, 1000 swap):
  - wb_data1 = ex_alu_out1; wb_data2 = ex_alu_out2; wb_wr1=1; wb_wr2=1.
- 1010 LBU:
  - a = ex_alu_out1[ADDR_W-1:0].
  - wb_data1 = {8'h00, mem[a]}; wb_wr1=1.
- 1011 SB:
  - mem[a] = ex_store_data[7:0].
  - wb_wr1=0, wb_wr2=0, wb_valid=1.
- 1100 LW and 1101 SW: big-endian words.
  - mem[a] holds bits 15:8; mem[(a+1) mod DMEM_BYTES] holds bits 7:0.
  - The address wraps from DMEM_BYTES-1 to 0.
  - LW writes wb_data1 with wb_wr1=1; SW produces no register write.
- Any other ex_op is a bubble: wb_valid=0.
- Exception handling (ex_exception=1 on an accepted instruction):
  - The instruction is squashed: wb_valid=0 and no memory write.
  - exc_pulse=1 for one cycle; exc_sticky is set.
  - Following instructions proceed normally.
- FSM states: IDLE and WORD2.
  - IDLE -> WORD2 on accept of a non-squashed LW or SW. The high byte is read or written on this edge.
  - WORD2 -> IDLE on the next edge. The low byte is read or written and the writeback bundle is registered.
  - mem_stall = (state == WORD2), combinational from state.
- In WORD2 the stage uses its own latched copy of op, address, data and dest. ex_* inputs are ignored.
- Memory contents are not reset.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE; mem_stall=0.
  - wb_valid, wb_wr1, wb_wr2, exc_pulse and exc_sticky are 0.
  - wb_data1, wb_data2 and wb_dest are 0.
- Single-cycle ops (including LBU and SB): outputs are valid 1 cycle after the accept edge and last exactly 1 cycle unless followed by another accept.
- LW and SW:
  - mem_stall is high during the cycle after the accept edge.
  - wb_valid=0 during that cycle.
  - The bundle is valid 2 cycles after accept.
  - Throughput is 1 word op per 2 cycles.
- Read-after-write to the same byte on consecutive cycles returns the new value. The write happens on edge N and the read on edge N+1.
- Reset asserted in WORD2:
  - The pending op is dropped with no writeback.
  - For SW, the high byte may already be written; the low byte is not.
- ex_valid=0: wb_valid=0 next cycle; wb_data holds its last value.

## Configuration
- ST4_ALIGN_CHECK_EN defined:
  - LW or SW with ex_alu_out1[0]=1 is treated as an exception.
  - The op is squashed, exc_pulse fires, exc_sticky is set and no stall occurs.
- ST4_ALIGN_CHECK_EN undefined:
  - Odd-address word access is legal.
  - It uses bytes a and (a+1) mod DMEM_BYTES.

## Test plan
- Reset: hold rst_n=0 mid-stream -> all outputs 0 and mem_stall=0 immediately; first op after release behaves normally.
- SB / LBU:
  - SB at 0x10 with data 0x12AB; next cycle LBU at 0x10, dest 3.
  - Required: wb_data1=0x00AB, wb_wr1=1, wb_dest=3, 1 cycle after LBU accept.
- SW / LW:
  - SW at 0x20 with 0xBEEF; then LW at 0x20.
  - Required: mem_stall high one cycle per op, mem[0x20]=0xBE, mem[0x21]=0xEF.
  - LW returns 0xBEEF 2 cycles after its accept.
- Wrap-around:
  - SW at 0xFF with 0x1234 (macro undefined) -> mem[0xFF]=0x12, mem[0x00]=0x34.
  - Same SW with the macro defined -> squashed, exc_pulse=1, memory unchanged.
- Exception squash:
  - Add with ex_exception=1, dest 5, then move 0x0042 to dest 6.
  - Required: no writeback for the add; exc_pulse for 1 cycle; exc_sticky=1.
  - Then wb_data1=0x0042 to dest 6.
- Two-result op:
  - mul with out1=0x5678, out2=0x1234.
  - Required: wb_wr1=1, wb_wr2=1, wb_data1=0x5678, wb_data2=0x1234.
  - Reset asserted in WORD2 of a LW returns to IDLE with wb_valid=0.

Source files
------------

// File: rtl/st4_mem.sv
// st4_mem: EX/MEM pipeline register with a byte-wide data memory. Word loads and stores take two cycles.
// Optional ST4_ALIGN_CHECK_EN: an odd-address LW/SW raises an exception instead of running.
module st4_mem #(
    parameter int unsigned DMEM_BYTES = 256,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [3:0]  ex_op,
    input  logic [15:0] ex_alu_out1,
    input  logic [15:0] ex_alu_out2,
    input  logic [15:0] ex_store_data,
    input  logic [3:0]  ex_dest,
    input  logic        ex_exception,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic [3:0]  wb_dest,
    output logic [15:0] wb_data1,
    output logic [15:0] wb_data2,
    output logic        wb_wr1,
    output logic        wb_wr2,
    output logic        exc_pulse,
    output logic        exc_sticky
);

    typedef enum logic {IDLE, WORD2} state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_ANDI = 4'h2,
        OP_MUL  = 4'h4,
        OP_DIV  = 4'h5,
        OP_MOVE = 4'h7,
        OP_SWAP = 4'h8,
        OP_ORI  = 4'h9,
        OP_LBU  = 4'hA,
        OP_SB   = 4'hB,
        OP_LW   = 4'hC,
        OP_SW   = 4'hD
    } op_t;

    state_t state, state_next;

    logic [7:0]        mem [DMEM_BYTES];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    logic              lat_is_sw;
    logic [ADDR_W-1:0] lat_addr;
    logic [ADDR_W-1:0] addr_next;
    logic [7:0]        lat_lo;
    logic [3:0]        lat_dest;
    logic [7:0]        hi_byte;

    logic              accept;
    logic              is_word;
    logic              misalign;
    logic              squash;
    logic              word_start;
    logic [ADDR_W-1:0] ex_addr;
    logic              unused_addr_bits;

    assign ex_addr          = ex_alu_out1[ADDR_W-1:0];
    assign unused_addr_bits = &{1'b0, ex_alu_out1[15:ADDR_W]};
    assign accept           = ex_valid && (state == IDLE);
    assign is_word          = (ex_op == OP_LW) || (ex_op == OP_SW);

`ifdef ST4_ALIGN_CHECK_EN
    assign misalign = is_word && ex_alu_out1[0];
`else
    assign misalign = 1'b0;
`endif

    assign squash     = ex_exception || misalign;
    assign word_start = accept && !squash && is_word;
    // Second byte of a word wraps naturally in ADDR_W bits.
    assign addr_next  = lat_addr + 1'b1;
    assign rd_addr    = (state == WORD2) ? addr_next : ex_addr;
    assign rd_data    = mem[rd_addr];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (word_start) state_next = WORD2;
            WORD2:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        mem_stall = (state == WORD2);
    end

    // Write port; held off during reset so a dropped SW never lands its low byte.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ex_addr;
        mem_wdata = ex_store_data[7:0];
        if (state == WORD2) begin
            if (lat_is_sw) begin
                mem_we    = 1'b1;
                mem_waddr = addr_next;
                mem_wdata = lat_lo;
            end
        end else if (accept && !squash) begin
            if (ex_op == OP_SB) begin
                mem_we = 1'b1;
            end else if (ex_op == OP_SW) begin
                mem_we    = 1'b1;
                mem_wdata = ex_store_data[15:8];
            end
        end
        if (!rst_n) mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_dest    <= '0;
            wb_data1   <= '0;
            wb_data2   <= '0;
            wb_wr1     <= 1'b0;
            wb_wr2     <= 1'b0;
            exc_pulse  <= 1'b0;
            exc_sticky <= 1'b0;
            lat_is_sw  <= 1'b0;
            lat_addr   <= '0;
            lat_lo     <= '0;
            lat_dest   <= '0;
            hi_byte    <= '0;
        end else begin
            wb_valid  <= 1'b0;
            wb_wr1    <= 1'b0;
            wb_wr2    <= 1'b0;
            exc_pulse <= 1'b0;
            if (state == WORD2) begin
                wb_valid <= 1'b1;
                wb_dest  <= lat_dest;
                if (!lat_is_sw) begin
                    wb_data1 <= {hi_byte, rd_data};
                    wb_wr1   <= 1'b1;
                end
            end else if (accept) begin
                if (squash) begin
                    exc_pulse  <= 1'b1;
                    exc_sticky <= 1'b1;
                end else begin
                    case (ex_op)
                        OP_ADD, OP_SUB, OP_ANDI, OP_MOVE, OP_ORI: begin
                            wb_valid <= 1'b1;
                            wb_dest  <= ex_dest;
                            wb_data1 <= ex_alu_out1;
                            wb_wr1   <= 1'b1;
                        end
                        OP_MUL, OP_DIV, OP_SWAP: begin
                            wb_valid <= 1'b1;
                            wb_dest  <= ex_dest;
                            wb_data1 <= ex_alu_out1;
                            wb_data2 <= ex_alu_out2;
                            wb_wr1   <= 1'b1;
                            wb_wr2   <= 1'b1;
                        end
                        OP_LBU: begin
                            wb_valid <= 1'b1;
                            wb_dest  <= ex_dest;
                            wb_data1 <= {8'h00, rd_data};
                            wb_wr1   <= 1'b1;
                        end
                        OP_SB: begin
                            wb_valid <= 1'b1;
                            wb_dest  <= ex_dest;
                        end
                        OP_LW, OP_SW: begin
                            lat_is_sw <= (ex_op == OP_SW);
                            lat_addr  <= ex_addr;
                            lat_lo    <= ex_store_data[7:0];
                            lat_dest  <= ex_dest;
                            hi_byte   <= rd_data;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_st4_mem.sv
// tb_st4_mem: directed vector table for st4_mem plus hand sequences for wrap-around and reset during WORD2.
// Expected values follow the ST4_ALIGN_CHECK_EN setting of the build.
module tb_st4_mem;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [15:0] ex_alu_out1;
    logic [15:0] ex_alu_out2;
    logic [15:0] ex_store_data;
    logic [3:0]  ex_dest;
    logic        ex_exception;
    logic        mem_stall;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic [15:0] wb_data1;
    logic [15:0] wb_data2;
    logic        wb_wr1;
    logic        wb_wr2;
    logic        exc_pulse;
    logic        exc_sticky;

    int total = 0;
    int bad   = 0;

    st4_mem #(.DMEM_BYTES(256), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_alu_out1(ex_alu_out1), .ex_alu_out2(ex_alu_out2),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_exception(ex_exception),
        .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_dest(wb_dest),
        .wb_data1(wb_data1), .wb_data2(wb_data2), .wb_wr1(wb_wr1), .wb_wr2(wb_wr2),
        .exc_pulse(exc_pulse), .exc_sticky(exc_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [15:0] o1;
        logic [15:0] o2;
        logic [15:0] sd;
        logic [3:0]  dest;
        logic        exc;
        logic        e_v;
        logic        e_wr1;
        logic        e_wr2;
        logic [3:0]  e_dest;
        logic [15:0] e_d1;
        logic [15:0] e_d2;
        logic        e_stall;
        logic        e_pulse;
        logic        e_sticky;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [3:0] op, logic [15:0] o1, logic [15:0] o2,
                                logic [15:0] sd, logic [3:0] dest, logic exc,
                                logic e_v, logic e_wr1, logic e_wr2, logic [3:0] e_dest,
                                logic [15:0] e_d1, logic [15:0] e_d2,
                                logic e_stall, logic e_pulse, logic e_sticky);
        vec_t r;
        r.v = v; r.op = op; r.o1 = o1; r.o2 = o2; r.sd = sd; r.dest = dest; r.exc = exc;
        r.e_v = e_v; r.e_wr1 = e_wr1; r.e_wr2 = e_wr2; r.e_dest = e_dest;
        r.e_d1 = e_d1; r.e_d2 = e_d2; r.e_stall = e_stall; r.e_pulse = e_pulse;
        r.e_sticky = e_sticky;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] o1,
                         input logic [15:0] o2, input logic [15:0] sd,
                         input logic [3:0] dest, input logic exc);
        ex_valid = v; ex_op = op; ex_alu_out1 = o1; ex_alu_out2 = o2;
        ex_store_data = sd; ex_dest = dest; ex_exception = exc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " valid"},  {15'd0, wb_valid},   16'h0);
        chk({tag, " stall"},  {15'd0, mem_stall},  16'h0);
        chk({tag, " wr1"},    {15'd0, wb_wr1},     16'h0);
        chk({tag, " wr2"},    {15'd0, wb_wr2},     16'h0);
        chk({tag, " pulse"},  {15'd0, exc_pulse},  16'h0);
        chk({tag, " sticky"}, {15'd0, exc_sticky}, 16'h0);
        chk({tag, " d1"},     wb_data1,            16'h0);
        chk({tag, " d2"},     wb_data2,            16'h0);
        chk({tag, " dest"},   {12'd0, wb_dest},    16'h0);
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b0, 4'h0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0);

        //          v  op     o1       o2       sd       dst  exc  eV eW1 eW2 eDst  eD1      eD2      stl pls stk
        vecs.push_back(mk(1, 4'h0, 16'h1111, 16'h0000, 16'h0000, 4'd1, 0, 1, 1, 0, 4'd1, 16'h1111, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 4'hB, 16'h0010, 16'h0000, 16'h12AB, 4'd9, 0, 1, 0, 0, 4'd9, 16'h1111, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 4'hA, 16'h0010, 16'h0000, 16'h0000, 4'd3, 0, 1, 1, 0, 4'd3, 16'h00AB, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 4'hD, 16'h0020, 16'h0000, 16'hBEEF, 4'd2, 0, 0, 0, 0, 4'd0, 16'h00AB, 16'h0000, 1, 0, 0));
        vecs.push_back(mk(1, 4'h0, 16'hDEAD, 16'h0000, 16'h0000, 4'd7, 0, 1, 0, 0, 4'd2, 16'h00AB, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 4'hC, 16'h0020, 16'h0000, 16'h0000, 4'd4, 0, 0, 0, 0, 4'd0, 16'h00AB, 16'h0000, 1, 0, 0));
        vecs.push_back(mk(1, 4'hA, 16'h0010, 16'h0000, 16'h0000, 4'd9, 0, 1, 1, 0, 4'd4, 16'hBEEF, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 4'hA, 16'h0020, 16'h0000, 16'h0000, 4'd5, 0, 1, 1, 0, 4'd5, 16'h00BE, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 4'hA, 16'h0021, 16'h0000, 16'h0000, 4'd5, 0, 1, 1, 0, 4'd5, 16'h00EF, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 4'h4, 16'h5678, 16'h1234, 16'h0000, 4'd8, 0, 1, 1, 1, 4'd8, 16'h5678, 16'h1234, 0, 0, 0));
        vecs.push_back(mk(0, 4'h0, 16'hFFFF, 16'hFFFF, 16'h0000, 4'd1, 0, 0, 0, 0, 4'd0, 16'h5678, 16'h1234, 0, 0, 0));
        vecs.push_back(mk(1, 4'h3, 16'hFFFF, 16'hFFFF, 16'h0000, 4'd1, 0, 0, 0, 0, 4'd0, 16'h5678, 16'h1234, 0, 0, 0));
        vecs.push_back(mk(1, 4'h1, 16'h0F0F, 16'h0000, 16'h0000, 4'd2, 0, 1, 1, 0, 4'd2, 16'h0F0F, 16'h1234, 0, 0, 0));
        vecs.push_back(mk(1, 4'h8, 16'hAAAA, 16'h5555, 16'h0000, 4'd1, 0, 1, 1, 1, 4'd1, 16'hAAAA, 16'h5555, 0, 0, 0));
        vecs.push_back(mk(1, 4'h2, 16'h0003, 16'h0000, 16'h0000, 4'd7, 0, 1, 1, 0, 4'd7, 16'h0003, 16'h5555, 0, 0, 0));
        vecs.push_back(mk(1, 4'h5, 16'h0007, 16'h0002, 16'h0000, 4'd9, 0, 1, 1, 1, 4'd9, 16'h0007, 16'h0002, 0, 0, 0));
        vecs.push_back(mk(1, 4'h9, 16'h00F0, 16'h0000, 16'h0000, 4'd2, 0, 1, 1, 0, 4'd2, 16'h00F0, 16'h0002, 0, 0, 0));
        vecs.push_back(mk(1, 4'h0, 16'h9999, 16'h0000, 16'h0000, 4'd5, 1, 0, 0, 0, 4'd0, 16'h00F0, 16'h0002, 0, 1, 1));
        vecs.push_back(mk(1, 4'h7, 16'h0042, 16'h0000, 16'h0000, 4'd6, 0, 1, 1, 0, 4'd6, 16'h0042, 16'h0002, 0, 0, 1));
        vecs.push_back(mk(1, 4'hB, 16'h0010, 16'h0000, 16'h0055, 4'd3, 1, 0, 0, 0, 4'd0, 16'h0042, 16'h0002, 0, 1, 1));
        vecs.push_back(mk(1, 4'hA, 16'h0010, 16'h0000, 16'h0000, 4'd3, 0, 1, 1, 0, 4'd3, 16'h00AB, 16'h0002, 0, 0, 1));
        vecs.push_back(mk(1, 4'hC, 16'h0020, 16'h0000, 16'h0000, 4'd4, 1, 0, 0, 0, 4'd0, 16'h00AB, 16'h0002, 0, 1, 1));
        vecs.push_back(mk(1, 4'h7, 16'h0001, 16'h0000, 16'h0000, 4'd1, 0, 1, 1, 0, 4'd1, 16'h0001, 16'h0002, 0, 0, 1));

        #2 rst_n = 1'b0;
        #1 chk_reset_state("reset");
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].o1, vecs[i].o2, vecs[i].sd, vecs[i].dest, vecs[i].exc);
            step();
            chk($sformatf("v%0d valid", i),  {15'd0, wb_valid},   {15'd0, vecs[i].e_v});
            chk($sformatf("v%0d stall", i),  {15'd0, mem_stall},  {15'd0, vecs[i].e_stall});
            chk($sformatf("v%0d pulse", i),  {15'd0, exc_pulse},  {15'd0, vecs[i].e_pulse});
            chk($sformatf("v%0d sticky", i), {15'd0, exc_sticky}, {15'd0, vecs[i].e_sticky});
            chk($sformatf("v%0d d1", i),     wb_data1,            vecs[i].e_d1);
            chk($sformatf("v%0d d2", i),     wb_data2,            vecs[i].e_d2);
            if (vecs[i].e_v) begin
                chk($sformatf("v%0d wr1", i),  {15'd0, wb_wr1},  {15'd0, vecs[i].e_wr1});
                chk($sformatf("v%0d wr2", i),  {15'd0, wb_wr2},  {15'd0, vecs[i].e_wr2});
                chk($sformatf("v%0d dest", i), {12'd0, wb_dest}, {12'd0, vecs[i].e_dest});
            end
        end

        // Wrap-around word access at the top of memory
        drive(1, 4'hB, 16'h00FF, 16'h0, 16'h00C3, 4'd0, 0); step();
        drive(1, 4'hB, 16'h0000, 16'h0, 16'h003C, 4'd0, 0); step();
        drive(1, 4'hD, 16'h00FF, 16'h0, 16'h1234, 4'd2, 0); step();
`ifndef ST4_ALIGN_CHECK_EN
        chk("wrap sw stall", {15'd0, mem_stall}, 16'h1);
        chk("wrap sw valid0", {15'd0, wb_valid}, 16'h0);
        drive(1, 4'hB, 16'h00FF, 16'h0, 16'h0000, 4'd0, 0); step();
        chk("wrap sw valid", {15'd0, wb_valid}, 16'h1);
        chk("wrap sw wr1", {15'd0, wb_wr1}, 16'h0);
        chk("wrap sw stall2", {15'd0, mem_stall}, 16'h0);
        drive(1, 4'hA, 16'h00FF, 16'h0, 16'h0, 4'd3, 0); step();
        chk("wrap rd ff", wb_data1, 16'h0012);
        drive(1, 4'hA, 16'h0000, 16'h0, 16'h0, 4'd3, 0); step();
        chk("wrap rd 00", wb_data1, 16'h0034);
        drive(1, 4'hC, 16'h00FF, 16'h0, 16'h0, 4'd4, 0); step();
        chk("wrap lw stall", {15'd0, mem_stall}, 16'h1);
        drive(0, 4'h0, 16'h0, 16'h0, 16'h0, 4'd0, 0); step();
        chk("wrap lw valid", {15'd0, wb_valid}, 16'h1);
        chk("wrap lw d1", wb_data1, 16'h1234);
        chk("wrap lw dest", {12'd0, wb_dest}, 16'h4);
`else
        chk("align sw stall", {15'd0, mem_stall}, 16'h0);
        chk("align sw valid", {15'd0, wb_valid}, 16'h0);
        chk("align sw pulse", {15'd0, exc_pulse}, 16'h1);
        drive(1, 4'hA, 16'h00FF, 16'h0, 16'h0, 4'd3, 0); step();
        chk("align rd ff", wb_data1, 16'h00C3);
        drive(1, 4'hA, 16'h0000, 16'h0, 16'h0, 4'd3, 0); step();
        chk("align rd 00", wb_data1, 16'h003C);
        drive(1, 4'hC, 16'h00FF, 16'h0, 16'h0, 4'd4, 0); step();
        chk("align lw stall", {15'd0, mem_stall}, 16'h0);
        chk("align lw pulse", {15'd0, exc_pulse}, 16'h1);
        chk("align lw valid", {15'd0, wb_valid}, 16'h0);
`endif

        // Reset during WORD2 of an LW
        drive(1, 4'hC, 16'h0020, 16'h0, 16'h0, 4'd4, 0); step();
        chk("rstlw stall", {15'd0, mem_stall}, 16'h1);
        drive(0, 4'h0, 16'h0, 16'h0, 16'h0, 4'd0, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset_state("rstlw async");
        step();
        rst_n = 1'b1;
        step();
        chk("rstlw valid", {15'd0, wb_valid}, 16'h0);
        chk("rstlw stall2", {15'd0, mem_stall}, 16'h0);

        // Reset during WORD2 of an SW: high byte landed, low byte did not
        drive(1, 4'hB, 16'h0040, 16'h0, 16'h0011, 4'd0, 0); step();
        drive(1, 4'hB, 16'h0041, 16'h0, 16'h0022, 4'd0, 0); step();
        drive(1, 4'hD, 16'h0040, 16'h0, 16'h99AA, 4'd0, 0); step();
        chk("rstsw stall", {15'd0, mem_stall}, 16'h1);
        drive(0, 4'h0, 16'h0, 16'h0, 16'h0, 4'd0, 0);
        #2 rst_n = 1'b0;
        #1 chk("rstsw stall0", {15'd0, mem_stall}, 16'h0);
        chk("rstsw valid0", {15'd0, wb_valid}, 16'h0);
        step();
        rst_n = 1'b1;
        drive(1, 4'hA, 16'h0040, 16'h0, 16'h0, 4'd3, 0); step();
        chk("rstsw rd40 valid", {15'd0, wb_valid}, 16'h1);
        chk("rstsw rd40", wb_data1, 16'h0099);
        drive(1, 4'hA, 16'h0041, 16'h0, 16'h0, 4'd3, 0); step();
        chk("rstsw rd41", wb_data1, 16'h0022);
        drive(0, 4'h0, 16'h0, 16'h0, 16'h0, 4'd0, 0); step();
        chk("idle valid", {15'd0, wb_valid}, 16'h0);
        chk("idle hold", wb_data1, 16'h0022);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
